sys_display_scan: RTL

SYS_DISPLAY_SCAN -- requirements
Module: sys_display_scan

---
 rtl/sys_display_scan.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sys_display_scan.sv
// Eight-digit multiplexed hex display scanner with tear-free frame-synchronous value updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module sys_display_scan #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [31:0] DISP_value,
  input  logic        DISP_load,
  input  logic        DISP_enable,
  output logic [6:0]  DISP_seg,
  output logic [7:0]  DISP_an,
  output logic [2:0]  DISP_digit_idx,
  output logic        DISP_frame_done
);

  localparam logic [15:0] CNT_LAST  = 16'(PRESCALE - 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [7:0]  AN_BLANK  = 8'hFF;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [31:0] shadow, show;
  logic        pending;
  logic        active, tick, wrap, lit;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Highest digit holding a nonzero nibble; zero when the word is zero so digit 0 stays lit.
  function automatic logic [2:0] top_digit(input logic [31:0] v);
    logic [2:0] m;
    m = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) m = 3'(i);
    end
    return m;
  endfunction

  assign lit = (idx <= top_digit(show));
`else
  assign lit = 1'b1;
`endif

  // Counting only happens while scanning and staying in SCAN; leaving clears everything next edge.
  assign active = (state == SCAN) && DISP_enable;
  assign tick   = active && (cnt == CNT_LAST);
  assign wrap   = tick && (idx == 3'd7);
  assign nibble = show[4*idx +: 4];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    cnt_next   = '0;
    idx_next   = '0;
    case (state)
      IDLE:    if (DISP_enable)  state_next = SCAN;
      SCAN:    if (!DISP_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (active) begin
      if (tick) begin
        cnt_next = '0;
        idx_next = idx + 3'd1;
      end else begin
        cnt_next = cnt + 16'd1;
        idx_next = idx;
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      DISP_frame_done <= 1'b0;
      DISP_an         <= AN_BLANK;
      DISP_seg        <= SEG_BLANK;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      idx             <= idx_next;
      DISP_frame_done <= wrap;
      if (active && lit) begin
        DISP_an  <= ~(8'b1 << idx);
        DISP_seg <= hex_to_seg(nibble);
      end else begin
        DISP_an  <= AN_BLANK;
        DISP_seg <= SEG_BLANK;
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      shadow  <= '0;
      show    <= '0;
      pending <= 1'b0;
    end else if (DISP_load && (state == IDLE)) begin
      shadow  <= DISP_value;
      show    <= DISP_value;
      pending <= 1'b0;
    end else begin
      // NOTE: non-blocking semantics make the later pending<=1 win over the commit's pending<=0,
      // and show still samples the pre-edge shadow when a load lands on the wrap.
      if (wrap && pending) begin
        show    <= shadow;
        pending <= 1'b0;
      end
      if (DISP_load) begin
        shadow  <= DISP_value;
        pending <= 1'b1;
      end
    end
  end

  assign DISP_digit_idx = idx;

endmodule
